pht_predictor: RTL and testbench

PHT_PREDICTOR -- requirements
Module: pht_predictor

---
 rtl/pht_predictor_pkg.sv | 23 ++
 rtl/pht_sat_counter.sv | 21 ++
 rtl/pht_predictor.sv | 124 ++++++++++++
 tb/tb_pht_predictor.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pht_predictor_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pht_predictor_pkg                                                     |
// | Shared defaults and 2-bit saturating counter arithmetic for the PHT.  |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
package pht_predictor_pkg;

    localparam int c_GHR_LEN = 12;
    localparam int c_IDX_W   = c_GHR_LEN + 1;

    localparam logic [1:0] c_CNT_MAX = 2'b11;
    localparam logic [1:0] c_CNT_MIN = 2'b00;

    function automatic logic [1:0] sat_next(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == c_CNT_MAX) ? c_CNT_MAX : cnt + 2'b01;
        end
        return (cnt == c_CNT_MIN) ? c_CNT_MIN : cnt - 2'b01;
    endfunction

endpackage : pht_predictor_pkg
`default_nettype wire

// File: rtl/pht_sat_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pht_sat_counter                                                       |
// | Next-value calculation for one 2-bit saturating direction counter.    |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module pht_sat_counter
    import pht_predictor_pkg::*;
(
    input  logic [1:0] i_counter,
    input  logic       i_taken,
    output logic [1:0] o_next,
    output logic       o_saturated
);

    assign o_next      = sat_next(i_counter, i_taken);
    // Already pinned in the outcome direction: the write would not change the entry.
    assign o_saturated = i_taken ? (i_counter == c_CNT_MAX) : (i_counter == c_CNT_MIN);

endmodule : pht_sat_counter
`default_nettype wire

// File: rtl/pht_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pht_predictor                                                         |
// | Gshare-style PHT front end: index/GHR management, registered response |
// | and registered counter write-back. Optional macro:                    |
// | PHT_SAT_WRITE_SKIP_EN suppresses writes that would not change a       |
// | saturated counter.                                                    |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module pht_predictor
    import pht_predictor_pkg::*;
#(
    parameter int GHR_LEN = c_GHR_LEN,
    parameter int IDX_W   = c_IDX_W
)(
    input  logic               clock,
    input  logic               reset,
    input  logic               pred_valid,
    input  logic [31:0]        pred_pc,
    output logic               pred_resp_valid,
    output logic               pred_taken,
    output logic [IDX_W-1:0]   pred_index,
    output logic [1:0]         pred_counter,
    output logic [GHR_LEN-1:0] pred_ghr,
    input  logic               upd_valid,
    input  logic               upd_taken,
    input  logic               upd_mispredict,
    input  logic [IDX_W-1:0]   upd_index,
    input  logic [1:0]         upd_counter,
    input  logic [GHR_LEN-1:0] upd_ghr,
    output logic               pht_ren,
    output logic [GHR_LEN-1:0] pht_raddr,
    input  logic [3:0]         pht_rdata,
    output logic               pht_wen,
    output logic [IDX_W-1:0]   pht_waddr,
    output logic [1:0]         pht_wdata
);

    logic [GHR_LEN-1:0] r_ghr;
    logic               r_stage_valid;
    logic [IDX_W-1:0]   r_stage_idx;
    logic [GHR_LEN-1:0] r_stage_ghr;
    logic               r_wen;
    logic [IDX_W-1:0]   r_waddr;
    logic [1:0]         r_wdata;

    logic [IDX_W-1:0]   w_idx;
    logic               w_kill;
    logic [1:0]         w_next_cnt;
    logic               w_saturated;
    logic               w_write;

    // ---------------- read request ----------------
    assign w_idx     = {pred_pc[GHR_LEN+2:3] ^ r_ghr, pred_pc[2]};
    assign w_kill    = upd_valid & upd_mispredict;
    assign pht_ren   = pred_valid & ~upd_mispredict;
    assign pht_raddr = w_idx[IDX_W-1:1];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_stage_valid <= 1'b0;
            r_stage_idx   <= '0;
            r_stage_ghr   <= '0;
        end else begin
            r_stage_valid <= pht_ren;
            r_stage_idx   <= w_idx;
            r_stage_ghr   <= r_ghr;
        end
    end

    // ---------------- response ----------------
    assign pred_counter    = r_stage_idx[0] ? pht_rdata[3:2] : pht_rdata[1:0];
    assign pred_taken      = pred_counter[1];
    assign pred_resp_valid = r_stage_valid & ~w_kill;
    assign pred_index      = r_stage_idx;
    assign pred_ghr        = r_stage_ghr;

    // A resolved mispredict restores history from the carried snapshot.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_ghr <= '0;
        end else if (w_kill) begin
            r_ghr <= {upd_ghr[GHR_LEN-2:0], upd_taken};
        end else if (pred_resp_valid) begin
            r_ghr <= {r_ghr[GHR_LEN-2:0], pred_taken};
        end
    end

    // ---------------- write-back ----------------
    pht_sat_counter u_sat_counter (
        .i_counter   (upd_counter),
        .i_taken     (upd_taken),
        .o_next      (w_next_cnt),
        .o_saturated (w_saturated)
    );

`ifdef PHT_SAT_WRITE_SKIP_EN
    assign w_write = upd_valid & ~w_saturated;
    logic w_unused_bits;
    assign w_unused_bits = ^{pred_pc[31:GHR_LEN+3], pred_pc[1:0], upd_ghr[GHR_LEN-1]};
`else
    assign w_write = upd_valid;
    logic w_unused_bits;
    assign w_unused_bits = ^{pred_pc[31:GHR_LEN+3], pred_pc[1:0], upd_ghr[GHR_LEN-1], w_saturated};
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wen   <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
        end else begin
            r_wen   <= w_write;
            r_waddr <= upd_index;
            r_wdata <= w_next_cnt;
        end
    end

    assign pht_wen   = r_wen;
    assign pht_waddr = r_waddr;
    assign pht_wdata = r_wdata;

endmodule : pht_predictor
`default_nettype wire

// File: tb/tb_pht_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pht_predictor                                                      |
// | Directed and randomized checks against a behavioural predictor model. |
// | Rev 1.0 - initial release                                             |
// +----------------------------------------------------------------------+
module tb_pht_predictor;

    localparam int GL    = 12;
    localparam int IW    = 13;
    localparam int NCNT  = 1 << IW;
    localparam int GMASK = (1 << GL) - 1;

    logic          clock = 1'b0;
    logic          reset;
    logic          pred_valid;
    logic [31:0]   pred_pc;
    logic          pred_resp_valid;
    logic          pred_taken;
    logic [IW-1:0] pred_index;
    logic [1:0]    pred_counter;
    logic [GL-1:0] pred_ghr;
    logic          upd_valid;
    logic          upd_taken;
    logic          upd_mispredict;
    logic [IW-1:0] upd_index;
    logic [1:0]    upd_counter;
    logic [GL-1:0] upd_ghr;
    logic          pht_ren;
    logic [GL-1:0] pht_raddr;
    logic [3:0]    pht_rdata;
    logic          pht_wen;
    logic [IW-1:0] pht_waddr;
    logic [1:0]    pht_wdata;

    always #5 clock = ~clock;

    pht_predictor dut (
        .clock(clock), .reset(reset),
        .pred_valid(pred_valid), .pred_pc(pred_pc),
        .pred_resp_valid(pred_resp_valid), .pred_taken(pred_taken),
        .pred_index(pred_index), .pred_counter(pred_counter), .pred_ghr(pred_ghr),
        .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
        .upd_index(upd_index), .upd_counter(upd_counter), .upd_ghr(upd_ghr),
        .pht_ren(pht_ren), .pht_raddr(pht_raddr), .pht_rdata(pht_rdata),
        .pht_wen(pht_wen), .pht_waddr(pht_waddr), .pht_wdata(pht_wdata)
    );

    // PHT storage seen by the DUT: registered read, write at the same edge.
    logic [1:0] mem [0:NCNT-1];
    always @(posedge clock) begin
        if (pht_ren) pht_rdata <= {mem[{pht_raddr, 1'b1}], mem[{pht_raddr, 1'b0}]};
        if (pht_wen) mem[pht_waddr] <= pht_wdata;
    end

    // Reference model state
    int m_pht [0:NCNT-1];
    int m_ghr, m_sidx, m_sghr, m_sdata, m_waddr, m_wdata;
    bit m_sv, m_wen;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int model_next(input int c, input bit t);
        if (t) return (c == 3) ? 3 : c + 1;
        return (c == 0) ? 0 : c - 1;
    endfunction

    function automatic bit model_skip(input int c, input bit t);
`ifdef PHT_SAT_WRITE_SKIP_EN
        return (t && c == 3) || (!t && c == 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic set_idle();
        pred_valid = 0; pred_pc = 0; upd_valid = 0; upd_taken = 0;
        upd_mispredict = 0; upd_index = 0; upd_counter = 0; upd_ghr = 0;
    endtask

    task automatic fill_mem(input bit rnd);
        for (int i = 0; i < NCNT; i++) begin
            int v;
            v = rnd ? int'($urandom_range(0, 3)) : 2;
            mem[i] = v[1:0];
            m_pht[i] = v;
        end
    endtask

    // One clock cycle: inputs already driven after a negedge.
    task automatic tick();
        bit kill, e_ren, e_resp, skip;
        int idx, e_cnt, nc;
        #1;
        kill   = upd_valid && upd_mispredict;
        e_ren  = pred_valid && !upd_mispredict;
        idx    = ((((pred_pc >> 3) ^ m_ghr) & GMASK) * 2) + int'(pred_pc[2]);
        e_resp = m_sv && !kill;
        e_cnt  = (m_sdata >> ((m_sidx % 2) * 2)) % 4;
        check_eq("pht_ren", 32'(pht_ren), 32'(e_ren));
        if (e_ren) check_eq("pht_raddr", 32'(pht_raddr), idx / 2);
        check_eq("resp_valid", 32'(pred_resp_valid), 32'(e_resp));
        if (e_resp) begin
            check_eq("pred_counter", 32'(pred_counter), e_cnt);
            check_eq("pred_taken", 32'(pred_taken), e_cnt / 2);
            check_eq("pred_index", 32'(pred_index), m_sidx);
            check_eq("pred_ghr", 32'(pred_ghr), m_sghr);
        end
        check_eq("pht_wen", 32'(pht_wen), 32'(m_wen));
        if (m_wen) begin
            check_eq("pht_waddr", 32'(pht_waddr), m_waddr);
            check_eq("pht_wdata", 32'(pht_wdata), m_wdata);
        end
        @(posedge clock);
        if (!reset && e_ren)
            m_sdata = m_pht[(idx / 2) * 2 + 1] * 4 + m_pht[(idx / 2) * 2];
        if (m_wen) m_pht[m_waddr] = m_wdata;
        if (reset) begin
            m_ghr = 0; m_sv = 0; m_wen = 0;
        end else begin
            m_sv   = e_ren;
            m_sidx = idx;
            m_sghr = m_ghr;
            if (kill)        m_ghr = ((int'(upd_ghr) * 2) + int'(upd_taken)) & GMASK;
            else if (e_resp) m_ghr = ((m_ghr * 2) + e_cnt / 2) & GMASK;
            nc      = model_next(int'(upd_counter), upd_taken);
            skip    = model_skip(int'(upd_counter), upd_taken);
            m_wen   = upd_valid && !skip;
            m_waddr = int'(upd_index);
            m_wdata = nc;
        end
        @(negedge clock);
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    // Request at pc 0 so the following response exposes the current GHR.
    task automatic probe_ghr(input int exp_ghr);
        pred_valid = 1; pred_pc = 0;
        tick();
        set_idle();
        #1 check_eq("probe_ghr", 32'(pred_ghr), exp_ghr);
        tick();
    endtask

    initial begin
        set_idle();
        reset = 1;
        fill_mem(0);
        m_ghr = 0; m_sv = 0; m_wen = 0; m_sdata = 0; m_sidx = 0; m_sghr = 0;
        m_waddr = 0; m_wdata = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 0;
        check_eq("reset_wen", 32'(pht_wen), 0);
        check_eq("reset_resp", 32'(pred_resp_valid), 0);

        // Directed: first prediction after reset
        mem[12'h200 * 2] = 2'b00; m_pht[12'h200 * 2] = 0;
        mem[12'h200 * 2 + 1] = 2'b11; m_pht[12'h200 * 2 + 1] = 3;
        do_reset();
        pred_valid = 1; pred_pc = 32'h1004;
        #1 check_eq("d1_raddr", 32'(pht_raddr), 32'h200);
        tick();
        set_idle();
        #1;
        check_eq("d1_resp", 32'(pred_resp_valid), 1);
        check_eq("d1_counter", 32'(pred_counter), 3);
        check_eq("d1_taken", 32'(pred_taken), 1);
        check_eq("d1_index", 32'(pred_index), 32'h401);
        check_eq("d1_ghr", 32'(pred_ghr), 0);
        tick();

        // Directed: three back-to-back taken predictions
        do_reset();
        repeat (3) begin
            pred_valid = 1; pred_pc = 0;
            tick();
        end
        set_idle();
        tick();
        probe_ghr(32'h007);

        // Directed: mispredict restores GHR and kills concurrent request
        upd_valid = 1; upd_mispredict = 1; upd_ghr = 12'h005; upd_taken = 0;
        upd_index = 13'h0010; upd_counter = 2;
        pred_valid = 1; pred_pc = 0;
        #1 check_eq("d3_ren", 32'(pht_ren), 0);
        tick();
        set_idle();
        #1 check_eq("d3_no_resp", 32'(pred_resp_valid), 0);
        probe_ghr(32'h00A);

        // Directed: saturated taken update
        upd_valid = 1; upd_index = 13'h1ABC; upd_counter = 3; upd_taken = 1;
        tick();
        set_idle();
        #1;
`ifdef PHT_SAT_WRITE_SKIP_EN
        check_eq("d4_wen", 32'(pht_wen), 0);
`else
        check_eq("d4_wen", 32'(pht_wen), 1);
        check_eq("d4_waddr", 32'(pht_waddr), 32'h1ABC);
        check_eq("d4_wdata", 32'(pht_wdata), 3);
`endif
        tick();

        // Directed: increment from 0, decrement from 1
        upd_valid = 1; upd_index = 13'h0033; upd_counter = 0; upd_taken = 1;
        tick();
        upd_counter = 1; upd_taken = 0;
        #1 check_eq("d5_inc", 32'(pht_wdata), 1);
        tick();
        set_idle();
        #1 check_eq("d5_dec", 32'(pht_wdata), 0);
        tick();

        // Directed: reset while a response and a write are pending
        pred_valid = 1; pred_pc = 32'h18;
        upd_valid = 1; upd_index = 13'h0044; upd_counter = 1; upd_taken = 1;
        reset = 1;
        tick();
        reset = 0;
        set_idle();
        #1;
        check_eq("d6_no_resp", 32'(pred_resp_valid), 0);
        check_eq("d6_no_wen", 32'(pht_wen), 0);
        tick();
        probe_ghr(0);

        // Randomized traffic
        fill_mem(1);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            reset          = ($urandom_range(0, 199) == 0);
            pred_valid     = ($urandom_range(0, 3) != 0);
            pred_pc        = $urandom & 32'h0000_00FC;
            upd_valid      = ($urandom_range(0, 2) == 0);
            upd_mispredict = ($urandom_range(0, 3) == 0);
            upd_taken      = $urandom_range(0, 1);
            upd_counter    = 2'($urandom_range(0, 3));
            upd_ghr        = 12'($urandom);
            upd_index      = ($urandom_range(0, 1) == 0) ? 13'(m_sidx) : 13'($urandom);
            tick();
        end
        reset = 0;
        set_idle();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pht_predictor
`default_nettype wire
